id_hazard_sequencer: RTL and testbench

//  Controls hazards for the decode (ID) stage. Each cycle it compares ID source

---
 rtl/id_hazard_sequencer.sv | 151 +++++++++++++++
 tb/tb_id_hazard_sequencer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/id_hazard_sequencer.sv
// id_hazard_sequencer
// Decode-stage hazard control. It picks operand forwarding sources for the
// ID stage and raises stall/bubble requests for load-use and branch/JR
// hazards. It also sequences a syscall: the pipeline is drained with
// SYS_BUBBLES bubbles, SYS is pulsed for one cycle, and one release bubble
// follows. A saturating counter records how many cycles were stalled.
module id_hazard_sequencer #(
   parameter int SYS_BUBBLES = 3,
   parameter int COUNT_W     = 16
) (
   input  logic               CLK,
   input  logic               RESET,
   input  logic [4:0]         ID_rs,
   input  logic [4:0]         ID_rt,
   input  logic               ID_use_rs,
   input  logic               ID_use_rt,
   input  logic               ID_branch_jr,
   input  logic               ID_syscall,
   input  logic [4:0]         EXE_dst,
   input  logic               EXE_regwrite,
   input  logic               EXE_memread,
   input  logic [4:0]         MEM_dst,
   input  logic               MEM_regwrite,
   input  logic               MEM_memread,
   output logic [1:0]         Fwd_Sel_A,
   output logic [1:0]         Fwd_Sel_B,
   output logic               Fwd_Stall,
   output logic               Insert_Bubble,
   output logic               SYS,
   output logic               Inhibit_Freeze,
   output logic [COUNT_W-1:0] Stall_Count
);

   typedef enum logic [1:0] {
      IDLE,
      DRAIN,
      SIGNAL,
      RELEASE
   } state_t;

   localparam logic [2:0]         CNT_INIT  = 3'(SYS_BUBBLES - 1);
   localparam logic [COUNT_W-1:0] COUNT_ONE = {{(COUNT_W-1){1'b0}}, 1'b1};

   state_t     state;
   state_t     state_next;
   logic [2:0] cnt;
   logic [2:0] cnt_next;

   logic rs_exe_match;
   logic rt_exe_match;
   logic rs_mem_match;
   logic rt_mem_match;
   logic exe_match;
   logic mem_match;
   logic hazard;

   // Register $0 is hard-wired to zero, so it never takes part in a match.
   assign rs_exe_match = ID_use_rs && (ID_rs != 5'd0) && (ID_rs == EXE_dst);
   assign rt_exe_match = ID_use_rt && (ID_rt != 5'd0) && (ID_rt == EXE_dst);
   assign rs_mem_match = ID_use_rs && (ID_rs != 5'd0) && (ID_rs == MEM_dst);
   assign rt_mem_match = ID_use_rt && (ID_rt != 5'd0) && (ID_rt == MEM_dst);
   assign exe_match    = rs_exe_match || rt_exe_match;
   assign mem_match    = rs_mem_match || rt_mem_match;

   // A load in EXE has no data yet; branch/JR need operands in ID, so an ALU
   // result still in EXE or a load still in MEM also forces a stall.
   assign hazard = (exe_match && EXE_memread)
                || (ID_branch_jr && exe_match && EXE_regwrite)
                || (ID_branch_jr && mem_match && MEM_memread);

   // Forwarding selects: the younger EXE result wins over MEM; a load in EXE
   // cannot forward, so it falls through to the MEM check.
   always_comb begin
      Fwd_Sel_A = 2'd0;
      Fwd_Sel_B = 2'd0;
      if (rs_exe_match && EXE_regwrite && !EXE_memread) begin
         Fwd_Sel_A = 2'd1;
      end else if (rs_mem_match && MEM_regwrite) begin
         Fwd_Sel_A = 2'd2;
      end
      if (rt_exe_match && EXE_regwrite && !EXE_memread) begin
         Fwd_Sel_B = 2'd1;
      end else if (rt_mem_match && MEM_regwrite) begin
         Fwd_Sel_B = 2'd2;
      end
   end

   // Next-state and stall/bubble outputs; hazards only matter in IDLE.
   always_comb begin
      state_next    = state;
      cnt_next      = cnt;
      Fwd_Stall     = 1'b0;
      Insert_Bubble = 1'b0;
      case (state)
         IDLE: begin
            if (hazard) begin
               Fwd_Stall     = 1'b1;
               Insert_Bubble = 1'b1;
            end else if (ID_syscall) begin
               state_next = DRAIN;
               cnt_next   = CNT_INIT;
            end
         end
         DRAIN: begin
            Fwd_Stall     = 1'b1;
            Insert_Bubble = 1'b1;
            if (cnt != 3'd0) begin
               cnt_next = cnt - 3'd1;
            end else begin
               state_next = SIGNAL;
            end
         end
         SIGNAL: begin
            state_next = RELEASE;
         end
         RELEASE: begin
            Insert_Bubble = 1'b1;
            state_next    = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // State register; SYS and Inhibit_Freeze are registered so they are high
   // exactly while the sequencer sits in SIGNAL.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state          <= IDLE;
         cnt            <= 3'd0;
         SYS            <= 1'b0;
         Inhibit_Freeze <= 1'b0;
      end else begin
         state          <= state_next;
         cnt            <= cnt_next;
         SYS            <= (state_next == SIGNAL);
         Inhibit_Freeze <= (state_next == SIGNAL);
      end
   end

   // Saturating count of stalled cycles; it sticks at all-ones.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         Stall_Count <= '0;
      end else if (Fwd_Stall && (Stall_Count != '1)) begin
         Stall_Count <= Stall_Count + COUNT_ONE;
      end
   end

endmodule

// File: tb/tb_id_hazard_sequencer.sv
// tb_id_hazard_sequencer
// Directed bench for id_hazard_sequencer with hand-computed expectations.
// Inputs change 1 ns after the rising edge and outputs are sampled a few
// ns later, well away from the edge.
module tb_id_hazard_sequencer;

   logic        CLK;
   logic        RESET;
   logic [4:0]  ID_rs;
   logic [4:0]  ID_rt;
   logic        ID_use_rs;
   logic        ID_use_rt;
   logic        ID_branch_jr;
   logic        ID_syscall;
   logic [4:0]  EXE_dst;
   logic        EXE_regwrite;
   logic        EXE_memread;
   logic [4:0]  MEM_dst;
   logic        MEM_regwrite;
   logic        MEM_memread;
   logic [1:0]  Fwd_Sel_A;
   logic [1:0]  Fwd_Sel_B;
   logic        Fwd_Stall;
   logic        Insert_Bubble;
   logic        SYS;
   logic        Inhibit_Freeze;
   logic [15:0] Stall_Count;

   int total;
   int bad;

   id_hazard_sequencer #(
      .SYS_BUBBLES(3),
      .COUNT_W(16)
   ) dut (
      .CLK(CLK),
      .RESET(RESET),
      .ID_rs(ID_rs),
      .ID_rt(ID_rt),
      .ID_use_rs(ID_use_rs),
      .ID_use_rt(ID_use_rt),
      .ID_branch_jr(ID_branch_jr),
      .ID_syscall(ID_syscall),
      .EXE_dst(EXE_dst),
      .EXE_regwrite(EXE_regwrite),
      .EXE_memread(EXE_memread),
      .MEM_dst(MEM_dst),
      .MEM_regwrite(MEM_regwrite),
      .MEM_memread(MEM_memread),
      .Fwd_Sel_A(Fwd_Sel_A),
      .Fwd_Sel_B(Fwd_Sel_B),
      .Fwd_Stall(Fwd_Stall),
      .Insert_Bubble(Insert_Bubble),
      .SYS(SYS),
      .Inhibit_Freeze(Inhibit_Freeze),
      .Stall_Count(Stall_Count)
   );

   // Free-running 10 ns clock.
   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      total++;
      if (observed !== expected) begin
         bad++;
         $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus();
      ID_rs        = 5'd0;
      ID_rt        = 5'd0;
      ID_use_rs    = 1'b0;
      ID_use_rt    = 1'b0;
      ID_branch_jr = 1'b0;
      ID_syscall   = 1'b0;
      EXE_dst      = 5'd0;
      EXE_regwrite = 1'b0;
      EXE_memread  = 1'b0;
      MEM_dst      = 5'd0;
      MEM_regwrite = 1'b0;
      MEM_memread  = 1'b0;
   endtask

   task automatic nextCycle();
      @(posedge CLK);
      #1;
   endtask

   // Directed scenarios in sequence, followed by the summary line.
   initial begin
      total = 0;
      bad   = 0;
      RESET = 1'b0;
      applyStimulus();

      // Reset state
      #12;
      checkOutput("rst_sys", SYS, 0);
      checkOutput("rst_inhibit", Inhibit_Freeze, 0);
      checkOutput("rst_count", Stall_Count, 0);
      checkOutput("rst_stall", Fwd_Stall, 0);
      checkOutput("rst_bubble", Insert_Bubble, 0);
      RESET = 1'b1;
      nextCycle();

      // 1: ALU forwarding from EXE, EXE priority over MEM, $0 never forwards
      ID_rs = 5'd5; ID_use_rs = 1'b1; EXE_dst = 5'd5; EXE_regwrite = 1'b1;
      #1;
      checkOutput("t1_selA", Fwd_Sel_A, 1);
      checkOutput("t1_stall", Fwd_Stall, 0);
      MEM_dst = 5'd5; MEM_regwrite = 1'b1;
      #1;
      checkOutput("t1_prio", Fwd_Sel_A, 1);
      EXE_regwrite = 1'b0;
      #1;
      checkOutput("t1_mem", Fwd_Sel_A, 2);
      ID_rs = 5'd0; EXE_dst = 5'd0; MEM_dst = 5'd0; EXE_regwrite = 1'b1;
      #1;
      checkOutput("t1_zero", Fwd_Sel_A, 0);
      applyStimulus();
      nextCycle();

      // 2: load-use on rt, then the load moves to MEM
      ID_rt = 5'd7; ID_use_rt = 1'b1; EXE_dst = 5'd7;
      EXE_regwrite = 1'b1; EXE_memread = 1'b1;
      #1;
      checkOutput("t2_stall", Fwd_Stall, 1);
      checkOutput("t2_bubble", Insert_Bubble, 1);
      checkOutput("t2_selB_load", Fwd_Sel_B, 0);
      nextCycle();
      EXE_dst = 5'd0; EXE_regwrite = 1'b0; EXE_memread = 1'b0;
      MEM_dst = 5'd7; MEM_regwrite = 1'b1;
      #1;
      checkOutput("t2_selB", Fwd_Sel_B, 2);
      checkOutput("t2_stall_off", Fwd_Stall, 0);
      checkOutput("t2_count", Stall_Count, 1);
      applyStimulus();
      nextCycle();

      // 3: branch on a register loaded in MEM stalls one cycle
      ID_branch_jr = 1'b1; ID_rs = 5'd3; ID_use_rs = 1'b1;
      MEM_dst = 5'd3; MEM_regwrite = 1'b1; MEM_memread = 1'b1;
      #1;
      checkOutput("t3_stall", Fwd_Stall, 1);
      checkOutput("t3_selA", Fwd_Sel_A, 2);
      nextCycle();
      MEM_dst = 5'd0; MEM_regwrite = 1'b0; MEM_memread = 1'b0;
      #1;
      checkOutput("t3_stall_off", Fwd_Stall, 0);
      EXE_dst = 5'd3; EXE_regwrite = 1'b1;
      #1;
      checkOutput("t3_br_exe", Fwd_Stall, 1);
      ID_branch_jr = 1'b0;
      #1;
      checkOutput("t3_nobr_exe", Fwd_Stall, 0);
      checkOutput("t3_count", Stall_Count, 2);
      applyStimulus();
      nextCycle();

      // 4: single syscall: 3 drain cycles, SIGNAL, RELEASE, IDLE
      ID_syscall = 1'b1;
      #1;
      checkOutput("t4_idle_stall", Fwd_Stall, 0);
      nextCycle();
      ID_syscall = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         checkOutput("t4_drain_stall", Fwd_Stall, 1);
         checkOutput("t4_drain_bubble", Insert_Bubble, 1);
         checkOutput("t4_drain_sys", SYS, 0);
         nextCycle();
      end
      ID_rs = 5'd4; ID_use_rs = 1'b1; EXE_dst = 5'd4;
      EXE_regwrite = 1'b1; EXE_memread = 1'b1;
      MEM_dst = 5'd4; MEM_regwrite = 1'b1;
      #1;
      checkOutput("t4_sig_sys", SYS, 1);
      checkOutput("t4_sig_inh", Inhibit_Freeze, 1);
      checkOutput("t4_sig_stall", Fwd_Stall, 0);
      checkOutput("t4_sig_bubble", Insert_Bubble, 0);
      checkOutput("t4_sig_selA", Fwd_Sel_A, 2);
      nextCycle();
      applyStimulus();
      ID_syscall = 1'b1;
      #1;
      checkOutput("t4_rel_sys", SYS, 0);
      checkOutput("t4_rel_inh", Inhibit_Freeze, 0);
      checkOutput("t4_rel_stall", Fwd_Stall, 0);
      checkOutput("t4_rel_bubble", Insert_Bubble, 1);
      nextCycle();
      ID_syscall = 1'b0;
      #1;
      checkOutput("t4_idle_after", Fwd_Stall, 0);
      checkOutput("t4_idle_bubble", Insert_Bubble, 0);
      checkOutput("t4_count", Stall_Count, 5);
      nextCycle();

      // 5: syscall held high: SYS at cycles 4 and 10, five quiet cycles between
      ID_syscall = 1'b1;
      for (int k = 0; k < 12; k++) begin
         #1;
         checkOutput("t5_sys", SYS, ((k % 6) == 4) ? 1 : 0);
         checkOutput("t5_stall", Fwd_Stall, ((k % 6) >= 1 && (k % 6) <= 3) ? 1 : 0);
         checkOutput("t5_bubble", Insert_Bubble,
                     (((k % 6) >= 1 && (k % 6) <= 3) || (k % 6) == 5) ? 1 : 0);
         nextCycle();
      end
      ID_syscall = 1'b0;
      #1;
      checkOutput("t5_count", Stall_Count, 11);
      nextCycle();

      // 6: reset in DRAIN with cnt=1 aborts the sequence
      ID_syscall = 1'b1;
      nextCycle();
      ID_syscall = 1'b0;
      nextCycle();
      #1;
      checkOutput("t6_drain", Fwd_Stall, 1);
      checkOutput("t6_count_pre", Stall_Count, 12);
      RESET = 1'b0;
      #1;
      checkOutput("t6_rst_sys", SYS, 0);
      checkOutput("t6_rst_stall", Fwd_Stall, 0);
      checkOutput("t6_rst_count", Stall_Count, 0);
      nextCycle();
      RESET = 1'b1;
      for (int k = 0; k < 7; k++) begin
         #1;
         checkOutput("t6_sys_quiet", SYS, 0);
         checkOutput("t6_stall_quiet", Fwd_Stall, 0);
         nextCycle();
      end

      // Saturation: hold a load-use hazard for 2^16+3 cycles
      ID_rs = 5'd9; ID_use_rs = 1'b1; EXE_dst = 5'd9;
      EXE_regwrite = 1'b1; EXE_memread = 1'b1;
      for (int k = 0; k < 65534; k++) begin
         nextCycle();
      end
      #1;
      checkOutput("sat_near", Stall_Count, 16'hFFFE);
      for (int k = 0; k < 5; k++) begin
         nextCycle();
      end
      #1;
      checkOutput("sat_full", Stall_Count, 16'hFFFF);
      applyStimulus();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
